// File: rtl/text_pkg.sv
// Shared constants, state encoding and buffer addressing helpers for the text console.
package text_pkg;

  localparam int unsigned COLS      = 70;
  localparam int unsigned ROWS      = 30;
  localparam int unsigned CHAR_W    = 9;
  localparam int unsigned CHAR_H    = 16;
  localparam int unsigned BUF_DEPTH = COLS * ROWS;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned COL_W     = 7;
  localparam int unsigned ROW_W     = 5;
  localparam int unsigned PIX_W     = 24;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;

  localparam logic [PIX_W-1:0] FG = 24'hFFFFFF;
  localparam logic [PIX_W-1:0] BG = 24'h000000;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_LINE
  } state_t;

  // Logical row to physical row: 6-bit add, one conditional subtract.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] top,
                                                input logic [ROW_W-1:0] row);
    logic [5:0] sum;
    sum = 6'(top) + 6'(row);
    if (sum >= 6'(ROWS)) sum = sum - 6'(ROWS);
    return ROW_W'(sum);
  endfunction

  // Physical row/column to linear buffer address.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/char_buf.sv
// Character screen buffer: one write port, one synchronous read-first read port.
module char_buf
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [BUF_DEPTH];

  // Write and read on the same edge; a colliding read sees the old byte.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_text_console.sv
// Text-mode console: keyboard-driven screen buffer plus 2-stage pixel pipeline to the font ROM.
module vga_text_console
  import text_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kb_valid,
  input  logic [7:0]       kb_ascii,
  output logic             kb_ready,
  input  logic [9:0]       h_addr,
  input  logic [9:0]       v_addr,
  input  logic             pix_valid,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [7:0]       font_ascii,
  output logic [3:0]       font_row,
  output logic [3:0]       font_col,
  input  logic             font_data,
  output logic [PIX_W-1:0] vga_data,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [COL_W-1:0] cursor_x,
  output logic [ROW_W-1:0] cursor_y
);

  state_t              state, state_next;
  logic [COL_W-1:0]    x_next;
  logic [ROW_W-1:0]    y_next;
  logic [ROW_W-1:0]    top, top_next;
  logic [ADDR_W-1:0]   cnt, cnt_next;
  logic                kb_ready_next;
  logic                newline;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [7:0]          wdata;

  logic [COL_W-1:0]    cx1;
  logic [5:0]          cy1;
  logic [3:0]          px1, py1;
  logic                val1, hs1, vs1;
  logic                on2, hs2, vs2;
  logic                in_range;
  logic [ADDR_W-1:0]   raddr;

  // Control state, cursor, scroll origin and clear counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR_ALL;
      cursor_x <= '0;
      cursor_y <= '0;
      top      <= '0;
      cnt      <= '0;
      kb_ready <= 1'b0;
    end else begin
      state    <= state_next;
      cursor_x <= x_next;
      cursor_y <= y_next;
      top      <= top_next;
      cnt      <= cnt_next;
      kb_ready <= kb_ready_next;
    end
  end

  // Next state, cursor movement and buffer write port.
  always_comb begin
    state_next = state;
    x_next     = cursor_x;
    y_next     = cursor_y;
    top_next   = top;
    cnt_next   = cnt;
    we         = 1'b0;
    waddr      = '0;
    wdata      = SPACE;
    newline    = 1'b0;
    case (state)
      CLEAR_ALL: begin
        we    = 1'b1;
        waddr = cnt;
        if (cnt == ADDR_W'(BUF_DEPTH - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ADDR_W'(1);
        end
      end
      CLEAR_LINE: begin
        we    = 1'b1;
        waddr = cell_addr(phys_row(top, ROW_W'(ROWS - 1)), COL_W'(cnt));
        if (cnt == ADDR_W'(COLS - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (kb_valid && kb_ready) begin
          if (kb_ascii >= SPACE && kb_ascii <= 8'h7E) begin
            we    = 1'b1;
            waddr = cell_addr(phys_row(top, cursor_y), cursor_x);
            wdata = kb_ascii;
            if (cursor_x == COL_W'(COLS - 1)) newline = 1'b1;
            else x_next = cursor_x + COL_W'(1);
          end else if (kb_ascii == LF || kb_ascii == CR) begin
            newline = 1'b1;
          end else if (kb_ascii == BS) begin
            if (cursor_x != '0) begin
              x_next = cursor_x - COL_W'(1);
              we     = 1'b1;
              waddr  = cell_addr(phys_row(top, cursor_y), cursor_x - COL_W'(1));
            end else if (cursor_y != '0) begin
              x_next = COL_W'(COLS - 1);
              y_next = cursor_y - ROW_W'(1);
              we     = 1'b1;
              waddr  = cell_addr(phys_row(top, cursor_y - ROW_W'(1)), COL_W'(COLS - 1));
            end
          end
          if (newline) begin
            x_next = '0;
            if (cursor_y != ROW_W'(ROWS - 1)) begin
              y_next = cursor_y + ROW_W'(1);
            end else begin
              top_next   = (top == ROW_W'(ROWS - 1)) ? '0 : top + ROW_W'(1);
              state_next = CLEAR_LINE;
              cnt_next   = '0;
            end
          end
        end
      end
      default: state_next = CLEAR_ALL;
    endcase
    kb_ready_next = (state_next == IDLE);
  end

  // Read address for the registered cell; off-screen cells read address 0.
  always_comb begin
    in_range = val1 && (cx1 < COL_W'(COLS)) && (cy1 < 6'(ROWS));
    raddr    = in_range ? cell_addr(phys_row(top, cy1[4:0]), cx1) : '0;
  end

  char_buf u_char_buf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (font_ascii)
  );

  // Display pipeline: cell coordinates, then font lookup, then colour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cx1       <= '0;
      cy1       <= '0;
      px1       <= '0;
      py1       <= '0;
      val1      <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
      font_row  <= '0;
      font_col  <= '0;
      on2       <= 1'b0;
      hs2       <= 1'b1;
      vs2       <= 1'b1;
      vga_data  <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      cx1       <= COL_W'(h_addr / 10'(CHAR_W));
      px1       <= 4'(h_addr % 10'(CHAR_W));
      cy1       <= v_addr[9:4];
      py1       <= v_addr[3:0];
      val1      <= pix_valid;
      hs1       <= hsync_in;
      vs1       <= vsync_in;
      font_row  <= py1;
      font_col  <= px1;
      on2       <= in_range;
      hs2       <= hs1;
      vs2       <= vs1;
      vga_data  <= on2 ? (font_data ? FG : BG) : '0;
      hsync_out <= hs2;
      vsync_out <= vs2;
    end
  end

endmodule

// File: tb/tb_vga_text_console.sv
// Randomized bench for vga_text_console against a logical-screen reference model.
module tb_vga_text_console;

  localparam int M_COLS = 70;
  localparam int M_ROWS = 30;
  localparam logic [23:0] M_FG = 24'hFFFFFF;
  localparam logic [23:0] M_BG = 24'h000000;

  logic        clk;
  logic        rst_n;
  logic        kb_valid;
  logic [7:0]  kb_ascii;
  logic        kb_ready;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        pix_valid;
  logic        hsync_in;
  logic        vsync_in;
  logic [7:0]  font_ascii;
  logic [3:0]  font_row;
  logic [3:0]  font_col;
  logic        font_data;
  logic [23:0] vga_data;
  logic        hsync_out;
  logic        vsync_out;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  int checks = 0;
  int errors = 0;

  logic [7:0] scr [M_ROWS][M_COLS];
  int mx, my;

  vga_text_console dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kb_valid   (kb_valid),
    .kb_ascii   (kb_ascii),
    .kb_ready   (kb_ready),
    .h_addr     (h_addr),
    .v_addr     (v_addr),
    .pix_valid  (pix_valid),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .font_ascii (font_ascii),
    .font_row   (font_row),
    .font_col   (font_col),
    .font_data  (font_data),
    .vga_data   (vga_data),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in font ROM: an arbitrary but character-dependent glyph pattern.
  function automatic logic font_fn(input logic [7:0] a, input logic [3:0] r, input logic [3:0] c);
    logic [2:0] k;
    k = 3'(r + c);
    return a[k] ^ (r[0] & c[0]);
  endfunction

  assign font_data = font_fn(font_ascii, font_row, font_col);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < M_ROWS; r++)
      for (int c = 0; c < M_COLS; c++) scr[r][c] = 8'h20;
    mx = 0;
    my = 0;
  endtask

  task automatic model_newline(output bit scrolled);
    scrolled = 1'b0;
    mx = 0;
    if (my < M_ROWS - 1) begin
      my++;
    end else begin
      for (int r = 0; r < M_ROWS - 1; r++)
        for (int c = 0; c < M_COLS; c++) scr[r][c] = scr[r + 1][c];
      for (int c = 0; c < M_COLS; c++) scr[M_ROWS - 1][c] = 8'h20;
      scrolled = 1'b1;
    end
  endtask

  task automatic model_apply(input logic [7:0] b, output bit scrolled);
    scrolled = 1'b0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[my][mx] = b;
      if (mx == M_COLS - 1) model_newline(scrolled);
      else mx++;
    end else if (b == 8'h0A || b == 8'h0D) begin
      model_newline(scrolled);
    end else if (b == 8'h08) begin
      if (mx > 0) begin
        mx--;
        scr[my][mx] = 8'h20;
      end else if (my > 0) begin
        my--;
        mx = M_COLS - 1;
        scr[my][mx] = 8'h20;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit wait_clear);
    int n;
    bit scrolled;
    n = 0;
    while (kb_ready !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      check("kb_ready_timeout", 32'(kb_ready), 32'(1));
      return;
    end
    kb_valid = 1'b1;
    kb_ascii = b;
    @(posedge clk); #1;
    kb_valid = 1'b0;
    model_apply(b, scrolled);
    check("cursor_x", 32'(cursor_x), 32'(mx));
    check("cursor_y", 32'(cursor_y), 32'(my));
    if (scrolled && wait_clear) begin
      n = 0;
      while (kb_ready !== 1'b1 && n < 200) begin
        n++;
        @(posedge clk); #1;
      end
      check("clear_line_len", 32'(n), 32'(M_COLS));
    end else if (!scrolled) begin
      check("kb_ready_idle", 32'(kb_ready), 32'(1));
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]), 1'b1);
  endtask

  task automatic reset_and_clear(input int low_cycles);
    int n;
    rst_n     = 1'b0;
    kb_valid  = 1'b0;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
    pix_valid = 1'b1;
    h_addr    = '0;
    v_addr    = '0;
    repeat (low_cycles) begin
      @(posedge clk); #1;
    end
    check("rst_kb_ready", 32'(kb_ready), 32'(0));
    check("rst_vga_data", 32'(vga_data), 32'(0));
    check("rst_hsync", 32'(hsync_out), 32'(1));
    check("rst_vsync", 32'(vsync_out), 32'(1));
    check("rst_cursor_x", 32'(cursor_x), 32'(0));
    check("rst_cursor_y", 32'(cursor_y), 32'(0));
    rst_n     = 1'b1;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    pix_valid = 1'b0;
    kb_valid  = 1'b1;
    kb_ascii  = 8'h41;
    n = 0;
    while (kb_ready !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    kb_valid = 1'b0;
    check("clear_all_len", 32'(n), 32'(M_COLS * M_ROWS));
    model_reset();
    check("post_clear_cursor_x", 32'(cursor_x), 32'(0));
    check("post_clear_cursor_y", 32'(cursor_y), 32'(0));
  endtask

  // mode 0: random anywhere, 1: sweep cell (0,0), 2: random within top text row.
  task automatic run_display(input int n, input int mode);
    logic [25:0] exp_q[$];
    logic [25:0] e;
    logic [23:0] col;
    int h, v, cx, cy;
    bit pv, hs, vs;
    for (int i = 0; i < n + 3; i++) begin
      if (i >= 3) begin
        e = exp_q.pop_front();
        check("vga_data", 32'(vga_data), 32'(e[25:2]));
        check("hsync_out", 32'(hsync_out), 32'(e[1]));
        check("vsync_out", 32'(vsync_out), 32'(e[0]));
      end
      if (i < n) begin
        case (mode)
          1: begin h = i % 9; v = i / 9; pv = 1'b1; end
          2: begin h = int'($urandom_range(0, 629)); v = int'($urandom_range(0, 15)); pv = 1'b1; end
          default: begin
            h  = int'($urandom_range(0, 719));
            v  = int'($urandom_range(0, 527));
            pv = ($urandom_range(0, 9) != 0);
          end
        endcase
        hs = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        cx = h / 9;
        cy = v / 16;
        col = 24'h0;
        if (pv && cx < M_COLS && cy < M_ROWS)
          col = font_fn(scr[cy][cx], 4'(v % 16), 4'(h % 9)) ? M_FG : M_BG;
        exp_q.push_back({col, hs, vs});
        h_addr    = 10'(h);
        v_addr    = 10'(v);
        pix_valid = pv;
        hsync_in  = hs;
        vsync_in  = vs;
      end else begin
        pix_valid = 1'b0;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic random_bytes(input int n);
    logic [7:0] b;
    int r;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55) b = 8'($urandom_range(32, 126));
      else if (r < 75) b = 8'h0A;
      else if (r < 80) b = 8'h0D;
      else if (r < 92) b = 8'h08;
      else begin
        b = 8'($urandom_range(0, 255));
        if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h0A || b == 8'h0D || b == 8'h08) b = 8'h7F;
      end
      send_byte(b, 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0; kb_valid = 1'b0; kb_ascii = '0;
    h_addr = '0; v_addr = '0; pix_valid = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    model_reset();

    reset_and_clear(3);
    send_byte(8'h08, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hC3, 1'b1);
    run_display(400, 0);

    send_str("A");
    run_display(144, 1);
    run_display(300, 0);

    for (int i = 0; i < 69; i++) send_byte(8'h78, 1'b1);
    run_display(600, 2);
    send_byte(8'h08, 1'b1);
    run_display(600, 2);

    send_byte(8'h0A, 1'b1);
    send_str("Row1!");
    for (int i = 0; i < 28; i++) send_byte(8'h0A, 1'b1);
    send_str("hello");
    send_byte(8'h0A, 1'b1);
    run_display(800, 2);
    run_display(500, 0);

    random_bytes(500);
    run_display(1500, 0);

    while (my != M_ROWS - 1) send_byte(8'h0A, 1'b1);
    send_byte(8'h0A, 1'b0);
    repeat (30) begin
      @(posedge clk); #1;
    end
    reset_and_clear(1);
    run_display(300, 0);
    send_str("Hi");
    send_byte(8'h0D, 1'b1);
    send_str("there");
    run_display(1000, 0);
    random_bytes(150);
    run_display(800, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
